mac_window_acc: RTL and testbench



---
 rtl/mac_window_acc_if.sv | 28 ++
 rtl/mac_window_acc.sv | 109 ++++++++++
 tb/tb_mac_window_acc.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_window_acc_if.sv
// Handshake bundle between the multiply-add result stream, the window
// accumulator and its result consumer.
interface mac_window_acc_if #(
  parameter int WIDTH_IN  = 17,
  parameter int N_SAMPLES = 4
);
  localparam int ACC_W = WIDTH_IN + $clog2(N_SAMPLES);

  logic                in_valid;
  logic [WIDTH_IN-1:0] in_data;
  logic                out_ready;
  logic                out_valid;
  logic [ACC_W-1:0]    out_sum;
  logic [WIDTH_IN-1:0] out_mean;
  logic [WIDTH_IN-1:0] out_max;
  logic                in_ready;
  logic [7:0]          drop_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_sum, out_mean, out_max, in_ready, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_sum, out_mean, out_max, in_ready, drop_cnt
  );
endinterface

// File: rtl/mac_window_acc.sv
// Window accumulator: sums, averages and peaks N_SAMPLES result words, with a
// one-entry skid absorbing the unstoppable upstream while a result is held.
//
// state | meaning
// ACC   | collecting samples into the running sum/max
// HOLD  | window result presented, waiting for out_ready
module mac_window_acc #(
  parameter int WIDTH_IN  = 17,
  parameter int N_SAMPLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  mac_window_acc_if.slave bus
);
  localparam int SHIFT = $clog2(N_SAMPLES);
  localparam int ACC_W = WIDTH_IN + SHIFT;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_nx;
  logic [ACC_W-1:0]    acc, sum_nx, sum_q;
  logic [WIDTH_IN-1:0] run_max, max_nx, skid, sample, max_q, mean_q;
  logic [SHIFT-1:0]    cnt;
  logic                skid_full, take, last;
  logic [7:0]          drop_q;

  // A held skid entry always has priority so sample order is preserved.
  always_comb begin
    take   = 1'b0;
    sample = skid;
    if (state == ACC) begin
      if (skid_full) begin
        take   = 1'b1;
        sample = skid;
      end else if (bus.in_valid) begin
        take   = 1'b1;
        sample = bus.in_data;
      end
    end
  end

  // N_SAMPLES is a power of two, so the final count is all ones.
  assign last   = take && (&cnt);
  assign sum_nx = acc + ACC_W'(sample);
  assign max_nx = (sample > run_max) ? sample : run_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (last) state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == HOLD);
    bus.in_ready  = (state == ACC);
    bus.out_sum   = sum_q;
    bus.out_mean  = mean_q;
    bus.out_max   = max_q;
    bus.drop_cnt  = drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      run_max   <= '0;
      cnt       <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      sum_q     <= '0;
      mean_q    <= '0;
      max_q     <= '0;
      drop_q    <= '0;
    end else if (state == ACC) begin
      if (skid_full) begin
        skid      <= bus.in_data;
        skid_full <= bus.in_valid;
      end
      if (take) begin
        if (last) begin
          sum_q   <= sum_nx;
          max_q   <= max_nx;
          mean_q  <= WIDTH_IN'(sum_nx >> SHIFT);
          acc     <= '0;
          run_max <= '0;
          cnt     <= '0;
        end else begin
          acc     <= sum_nx;
          run_max <= max_nx;
          cnt     <= cnt + 1'b1;
        end
      end
    end else if (bus.in_valid) begin
      if (!skid_full) begin
        skid      <= bus.in_data;
        skid_full <= 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mac_window_acc.sv
// Bench for mac_window_acc: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_mac_window_acc;
  localparam int WIDTH_IN  = 17;
  localparam int N_SAMPLES = 4;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  mac_window_acc_if #(.WIDTH_IN(WIDTH_IN), .N_SAMPLES(N_SAMPLES)) bus ();

  mac_window_acc #(.WIDTH_IN(WIDTH_IN), .N_SAMPLES(N_SAMPLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending-sample queue, the current window's samples,
  // and the last completed window's results.
  bit      m_hold;
  int      m_drop;
  longint  m_sum, m_mean, m_max;
  longint  win[$];
  longint  pend[$];

  function automatic void model_reset();
    m_hold = 0; m_drop = 0; m_sum = 0; m_mean = 0; m_max = 0;
    win.delete();
    pend.delete();
  endfunction

  function automatic void model_step(input bit v, input longint d, input bit r);
    longint s;
    bit     got;
    if (!m_hold) begin
      got = 0;
      s   = 0;
      if (pend.size() > 0) begin
        s = pend.pop_front();
        got = 1;
        if (v) pend.push_back(d);
      end else if (v) begin
        s = d;
        got = 1;
      end
      if (got) begin
        win.push_back(s);
        if (win.size() == N_SAMPLES) begin
          m_sum = 0;
          m_max = 0;
          foreach (win[i]) begin
            m_sum += win[i];
            if (win[i] > m_max) m_max = win[i];
          end
          m_mean = m_sum / N_SAMPLES;
          win.delete();
          m_hold = 1;
        end
      end
    end else begin
      if (v) begin
        if (pend.size() == 0) pend.push_back(d);
        else if (m_drop < 255) m_drop++;
      end
      if (r) m_hold = 0;
    end
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cmp_model();
    check("model out_valid", longint'(bus.out_valid), longint'(m_hold));
    check("model in_ready",  longint'(bus.in_ready),  longint'(!m_hold));
    check("model out_sum",   longint'(bus.out_sum),   m_sum);
    check("model out_mean",  longint'(bus.out_mean),  m_mean);
    check("model out_max",   longint'(bus.out_max),   m_max);
    check("model drop_cnt",  longint'(bus.drop_cnt),  longint'(m_drop));
  endtask

  task automatic step(input bit v, input logic [WIDTH_IN-1:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    model_step(v, longint'(d), r);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " out_valid"}, longint'(bus.out_valid), 0);
    check({tag, " in_ready"},  longint'(bus.in_ready),  1);
    check({tag, " out_sum"},   longint'(bus.out_sum),   0);
    check({tag, " out_mean"},  longint'(bus.out_mean),  0);
    check({tag, " out_max"},   longint'(bus.out_max),   0);
    check({tag, " drop_cnt"},  longint'(bus.drop_cnt),  0);
  endtask

  typedef struct {
    bit     v;
    int     d;
    bit     r;
    bit     ev;
    longint esum;
    longint emean;
    longint emax;
    longint edrop;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int windows;

    tbl[0]  = '{1, 1, 1, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 2, 1, 0,  0, 0, 0, 0};
    tbl[2]  = '{1, 3, 1, 0,  0, 0, 0, 0};
    tbl[3]  = '{1, 4, 1, 1, 10, 2, 4, 0};
    tbl[4]  = '{1, 5, 0, 1, 10, 2, 4, 0};
    tbl[5]  = '{1, 6, 0, 1, 10, 2, 4, 1};
    tbl[6]  = '{1, 7, 0, 1, 10, 2, 4, 2};
    tbl[7]  = '{0, 0, 1, 0, 10, 2, 4, 2};
    tbl[8]  = '{1, 1, 1, 0, 10, 2, 4, 2};
    tbl[9]  = '{1, 1, 1, 0, 10, 2, 4, 2};
    tbl[10] = '{1, 1, 1, 0, 10, 2, 4, 2};
    tbl[11] = '{0, 0, 1, 1,  8, 2, 5, 2};
    tbl[12] = '{1, 9, 1, 0,  8, 2, 5, 2};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: first window, then HOLD with skid/drops and a second window.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, WIDTH_IN'(tbl[i].d), tbl[i].r);
      check($sformatf("tbl[%0d] out_valid", i), longint'(bus.out_valid), longint'(tbl[i].ev));
      check($sformatf("tbl[%0d] in_ready", i),  longint'(bus.in_ready),  longint'(!tbl[i].ev));
      check($sformatf("tbl[%0d] out_sum", i),   longint'(bus.out_sum),   tbl[i].esum);
      check($sformatf("tbl[%0d] out_mean", i),  longint'(bus.out_mean),  tbl[i].emean);
      check($sformatf("tbl[%0d] out_max", i),   longint'(bus.out_max),   tbl[i].emax);
      check($sformatf("tbl[%0d] drop_cnt", i),  longint'(bus.drop_cnt),  tbl[i].edrop);
    end

    // Full-scale samples, continuous input, out_ready high.
    do_reset();
    windows = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 17'h1FFFF, 1);
      if (bus.out_valid) windows++;
    end
    check("fullscale windows",  longint'(windows),      3);
    check("fullscale out_sum",  longint'(bus.out_sum),  'h7FFFC);
    check("fullscale out_mean", longint'(bus.out_mean), 'h1FFFF);
    check("fullscale out_max",  longint'(bus.out_max),  'h1FFFF);

    // Reset asserted asynchronously in the middle of a window.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, WIDTH_IN'(i), 0);
    for (int i = 0; i < 3; i++) step(1, 17'd5, 0);
    step(0, 0, 1);
    step(1, 17'd3, 1);
    step(1, 17'd7, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 17'd10, 1);
    step(1, 17'd20, 1);
    step(1, 17'd30, 1);
    step(1, 17'd40, 1);
    check("postreset out_valid", longint'(bus.out_valid), 1);
    check("postreset out_sum",   longint'(bus.out_sum),   100);
    check("postreset out_mean",  longint'(bus.out_mean),  25);
    check("postreset out_max",   longint'(bus.out_max),   40);
    check("postreset drop_cnt",  longint'(bus.drop_cnt),  0);

    // Long stall in HOLD saturates the drop counter.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, WIDTH_IN'(i), 0);
    for (int i = 0; i < 300; i++) step(1, WIDTH_IN'($urandom), 0);
    check("saturate drop_cnt",  longint'(bus.drop_cnt),  255);
    check("saturate out_valid", longint'(bus.out_valid), 1);
    check("saturate out_sum",   longint'(bus.out_sum),   10);
    check("saturate out_max",   longint'(bus.out_max),   4);

    // Handshake cycle with a sample arriving while skid is occupied.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, WIDTH_IN'(i), 0);
    step(1, 17'd50, 0);
    step(1, 17'd60, 1);
    check("hs-drop drop_cnt",  longint'(bus.drop_cnt),  1);
    check("hs-drop out_valid", longint'(bus.out_valid), 0);
    step(1, 17'd1, 1);
    step(1, 17'd1, 1);
    step(1, 17'd1, 1);
    step(0, 17'd0, 1);
    check("hs-drop out_valid2", longint'(bus.out_valid), 1);
    check("hs-drop out_sum",    longint'(bus.out_sum),   53);
    check("hs-drop out_mean",   longint'(bus.out_mean),  13);
    check("hs-drop out_max",    longint'(bus.out_max),   50);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, WIDTH_IN'($urandom), $urandom_range(0, 9) < 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
